aes_gcm_api: RTL and testbench
==============================

# aes_gcm_api

AES-128 GCM counter-mode encryption front end with a fixed, parameterised key and IV. It takes 128-bit plaintext blocks, each tagged with a 289-bit bypass (metadata) word, and XORs each block with the AES keystream for the running GCM counter. It returns each ciphertext block with its bypass word and a one-cycle ready strobe. It sits between the packet framer and the GHASH/tag stage; tag computation is out of scope.

## Interface
- KEY, 128'hfeffe9928665731c6d6a8f9467308308, fixed AES-128 key.
- IV, 96'hcafebabefacedbaddecaf888, fixed 96-bit GCM IV.
- FIFO_DEPTH, 4, input queue entries; power of two.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- i_new  in  1  one-cycle strobe; block present on inputs this cycle.
- i_last  in  1  qualified by i_new; block is last of its message.
- i_plain_text  in  128  plaintext. Stream byte k (0 = first) is at [8k+7:8k].
- i_bypass_text  in  289  metadata carried unchanged alongside the block.
- o_bypass_text  out  289  bypass word of the block currently presented.
- o_cipher_text  out  [0:127]  ciphertext, big-endian. Stream byte k is at [8k:8k+7].
- o_cp_ready  out  1  one-cycle strobe; o_cipher_text and o_bypass_text valid.

## Operation
- Keystream for each block: E(KEY, IV || CTR), where CTR is a 32-bit big-endian counter.
- CTR is 2 for the first block after reset, and for the first block after a block that had i_last set.
- CTR increments by 1 per block, modulo 2^32 (0xFFFFFFFF wraps to 0).
- Ciphertext = byte-reordered plaintext XOR keystream.
- AES is iterative: initial AddRoundKey, then one round per cycle for rounds 1–10. Round 10 has no MixColumns.
- Round keys derive from KEY at elaboration or during reset. There is no runtime key change.
- Each accepted {plaintext, bypass, last} entry is pushed into a FIFO of FIFO_DEPTH entries. The core pops the FIFO when idle.
- The counter value is bound to the block at pop time. Counter reset on i_last takes effect after that block is popped.
- i_new while the FIFO is full: the block is dropped silently and the counter is unaffected.
- There is no backpressure. Upstream keeps i_new rate at or below one per 11 cycles on average.
- Outputs hold their last value between strobes.

## Timing
- Reset: o_cp_ready=0, o_cipher_text=0, o_bypass_text=0. FIFO emptied, core idle, CTR=2.
- Reset mid-operation discards all queued and in-flight blocks; no strobe follows.
- Cycle 0: i_new sampled and entry written.
- Cycle 1: popped, if the core is idle and the FIFO held no older entries; AddRoundKey applied.
- Cycles 2–11: rounds 1–10.
- Cycle 12: o_cp_ready=1 with registered outputs. Latency is 12 cycles from an idle core.
- Core throughput is one block per 11 cycles. Queued blocks produce strobes exactly 11 cycles apart.
- i_new at the same edge as a pop: the push and the pop both occur. The pushed entry queues behind any existing entries.
- o_cp_ready is never high on two consecutive cycles.

## Test plan
- Reset 2 cycles, then one i_new with plaintext D9313225F88406E5A55909C5AFF5269A (stream order), i_last=1 -> o_cp_ready exactly 12 cycles later. o_cipher_text = 42831ec2217774244b7221b784d0d49c; o_bypass_text equals the input bypass word.
- Three blocks, same plaintext, i_new every 2 cycles, bypass words B+1, B+2, B+3, last on the third:
  - strobes 11 cycles apart;
  - first ciphertext 42831ec2217774244b7221b784d0d49c;
  - second ciphertext bc3cba59c1b255dfbed447db0c680dc6 (CTR=3);
  - bypass words returned in order.
- Repeat the three-block message after the previous last -> identical ciphertexts; the counter restarted at 2.
- Five i_new back-to-back with FIFO_DEPTH=4 and an idle core -> five strobes. The first block pops immediately, so no drop occurs. A sixth i_new in the next cycle is dropped: no sixth strobe.
- Assert reset 5 cycles after i_new -> no strobe. Outputs are 0 during and after reset, and the next block uses CTR=2.
- Force CTR to 0xFFFFFFFF via a message of 2^32-2 blocks or a bench backdoor -> the following block uses CTR=0.

Source files
------------

// File: rtl/aes_gcm_api.sv
// AES-128 counter-mode front end with a fixed key and IV. It has a small input FIFO
// and an iterative cipher core that runs one round per cycle.
module aes_gcm_api #(
  parameter logic [127:0] KEY        = 128'hfeffe9928665731c6d6a8f9467308308,
  parameter logic [95:0]  IV         = 96'hcafebabefacedbaddecaf888,
  parameter int           FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_new,
  input  logic         i_last,
  input  logic [127:0] i_plain_text,
  input  logic [288:0] i_bypass_text,
  output logic [288:0] o_bypass_text,
  output logic [0:127] o_cipher_text,
  output logic         o_cp_ready
);

  // Handshake: i_new is a one-cycle strobe. It has no ready, and entries that arrive
  // while the FIFO is full are dropped. o_cp_ready is a one-cycle valid. It also has
  // no backpressure, and the outputs hold their value between strobes.

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    int idx;
    idx = 255 - int'(x);
    return SBOX_TBL[idx*8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // State is big-endian: byte n sits at [127-8n -: 8], and column c holds bytes 4c..4c+3.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last_round);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] r;
    for (int n = 0; n < 16; n++) b[n] = sbox(s[127-8*n -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c+rr)%4)+rr];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (last_round)
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r ^ k;
  endfunction

  // The whole schedule folds to a constant because KEY is a parameter. Round key i is at [i*128 +: 128].
  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 11; i++) r[i*128 +: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
    return r;
  endfunction

  localparam logic [1407:0] RK_ALL   = expand_key(KEY);
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic {S_IDLE, S_ROUND} core_state_t;

  core_state_t   core_state;
  logic [3:0]    rnd;
  logic [127:0]  state_q;
  logic [127:0]  cur_pt;
  logic [288:0]  cur_byp;
  logic          fin;
  logic [31:0]   ctr;

  logic [127:0]  fifo_pt   [FIFO_DEPTH];
  logic [288:0]  fifo_byp  [FIFO_DEPTH];
  logic          fifo_last [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [127:0]  pt_be;

  // Reverse the byte order of the plaintext so that stream byte 0 lands in the MSB,
  // the same position as byte 0 of the keystream.
  always_comb begin
    pt_be = '0;
    for (int k = 0; k < 16; k++) pt_be[127-8*k -: 8] = i_plain_text[8*k +: 8];
  end

  assign push = i_new && (count != FULL_CNT);
  assign pop  = (core_state == S_IDLE) && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pt[wr_ptr]   <= pt_be;
      fifo_byp[wr_ptr]  <= i_bypass_text;
      fifo_last[wr_ptr] <= i_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      core_state    <= S_IDLE;
      rnd           <= 4'd0;
      state_q       <= '0;
      cur_pt        <= '0;
      cur_byp       <= '0;
      fin           <= 1'b0;
      ctr           <= 32'd2;
      o_cp_ready    <= 1'b0;
      o_cipher_text <= '0;
      o_bypass_text <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      o_cp_ready <= fin;
      fin        <= 1'b0;
      if (fin) begin
        o_cipher_text <= state_q ^ cur_pt;
        o_bypass_text <= cur_byp;
      end

      // The core is idle on the same cycle that the output is registered. This lets
      // back-to-back blocks come out 11 cycles apart.
      case (core_state)
        S_IDLE: begin
          if (pop) begin
            state_q    <= {IV, ctr} ^ RK_ALL[127:0];
            cur_pt     <= fifo_pt[rd_ptr];
            cur_byp    <= fifo_byp[rd_ptr];
            ctr        <= fifo_last[rd_ptr] ? 32'd2 : ctr + 32'd1;
            rnd        <= 4'd1;
            core_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          state_q <= aes_round(state_q, RK_ALL[rnd*128 +: 128], rnd == 4'd10);
          rnd     <= rnd + 4'd1;
          if (rnd == 4'd10) begin
            core_state <= S_IDLE;
            fin        <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_gcm_api.sv
// Bench for aes_gcm_api: a behavioural AES model feeds a scoreboard of expected
// {strobe cycle, bypass, ciphertext} entries, plus directed checks from the test plan.
module tb_aes_gcm_api;

  localparam logic [127:0] KEY = 128'hfeffe9928665731c6d6a8f9467308308;
  localparam logic [95:0]  IV  = 96'hcafebabefacedbaddecaf888;
  localparam int           W   = 449;
  localparam logic [127:0] PT0 = 128'hd9313225f88406e5a55909c5aff5269a;
  localparam logic [127:0] CT2 = 128'h42831ec2217774244b7221b784d0d49c;
  localparam logic [127:0] CT3 = 128'hbc3cba59c1b255dfbed447db0c680dc6;
  localparam logic [288:0] BYP = {33'h1_2345_6789, 256'hdead_beef_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd};

  logic         clk = 1'b0;
  logic         reset;
  logic         i_new;
  logic         i_last;
  logic [127:0] i_plain_text;
  logic [288:0] i_bypass_text;
  logic [288:0] o_bypass_text;
  logic [0:127] o_cipher_text;
  logic         o_cp_ready;

  aes_gcm_api dut (
    .clk           (clk),
    .reset         (reset),
    .i_new         (i_new),
    .i_last        (i_last),
    .i_plain_text  (i_plain_text),
    .i_bypass_text (i_bypass_text),
    .o_bypass_text (o_bypass_text),
    .o_cipher_text (o_cipher_text),
    .o_cp_ready    (o_cp_ready)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [127:0] obs_ct[$];
  logic [7:0]   m_sbox [256];
  logic [31:0]  m_ctr = 32'd2;
  int           core_free = 0;
  logic         prev_rdy = 1'b0;
  logic [W-1:0] e;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gf_mul(inv, 8'(x));
      m_sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_aes(input logic [127:0] blk);
    logic [7:0]   st [16];
    logic [7:0]   sb [16];
    logic [7:0]   kb [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int n = 0; n < 16; n++) begin
      kb[n] = KEY[127-8*n -: 8];
      st[n] = blk[127-8*n -: 8] ^ kb[n];
    end
    for (int r = 1; r <= 10; r++) begin
      kb[0] = kb[0] ^ m_sbox[kb[13]] ^ rc;
      kb[1] = kb[1] ^ m_sbox[kb[14]];
      kb[2] = kb[2] ^ m_sbox[kb[15]];
      kb[3] = kb[3] ^ m_sbox[kb[12]];
      for (int n = 4; n < 16; n++) kb[n] = kb[n] ^ kb[n-4];
      rc = gf_mul(rc, 8'h02);
      for (int n = 0; n < 16; n++) sb[n] = m_sbox[st[n]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) st[4*c+rr] = sb[4*((c+rr)%4)+rr];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
          st[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) st[n] = st[n] ^ kb[n];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
    return res;
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = v[8*k +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [288:0] rand289();
    logic [288:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom();
    r[288] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; the block is sampled at the following posedge.
  task automatic send(input logic [127:0] pt, input logic [288:0] byp, input logic last,
                      input logic accept);
    int push_cyc, pop_cyc;
    i_new         = 1'b1;
    i_last        = last;
    i_plain_text  = bswap(pt);
    i_bypass_text = byp;
    if (accept) begin
      push_cyc  = cyc + 1;
      pop_cyc   = (push_cyc + 1 > core_free) ? push_cyc + 1 : core_free;
      core_free = pop_cyc + 11;
      exp_q.push_back({32'(pop_cyc + 11), byp, model_aes({IV, m_ctr}) ^ pt});
      m_ctr = last ? 32'd2 : m_ctr + 32'd1;
    end
    @(negedge clk);
    i_new  = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [288:0] got, input logic [288:0] expv);
    checks++;
    assert (got === expv)
      else begin errors++; $error("FAIL %s: got %h expected %h", tag, got, expv); end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0)
      else begin errors++; $error("FAIL %s_timeout: pending %0d expected 0", tag, exp_q.size()); end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (o_cp_ready) begin
      checks++;
      assert (!prev_rdy)
        else begin errors++; $error("FAIL ready_width: got two strobes in a row at cycle %0d", cyc); end
      checks++;
      assert (exp_q.size() != 0)
        else begin errors++; $error("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc); end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks += 3;
        assert (o_cipher_text === e[127:0])
          else begin errors++; $error("FAIL cipher: got %h expected %h", o_cipher_text, e[127:0]); end
        assert (o_bypass_text === e[416:128])
          else begin errors++; $error("FAIL bypass: got %h expected %h", o_bypass_text, e[416:128]); end
        assert (cyc === int'(e[448:417]))
          else begin errors++; $error("FAIL strobe_cycle: got %0d expected %0d", cyc, e[448:417]); end
      end
      obs_ct.push_back(o_cipher_text);
    end
    prev_rdy = o_cp_ready;
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; i_new = 1'b0; i_last = 1'b0; i_plain_text = '0; i_bypass_text = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 289'(o_cp_ready), 289'(0));
    chk("reset_cipher", 289'(o_cipher_text), 289'(0));
    chk("reset_bypass", o_bypass_text, 289'(0));
    reset = 1'b0;
    @(negedge clk);

    // A single block, last=1: latency 12 and known ciphertext.
    obs_ct.delete();
    send(PT0, BYP, 1'b1, 1'b1);
    wait_drain("single");
    chk("single_ct", 289'(obs_ct[0]), 289'(CT2));
    repeat (5) @(negedge clk);
    chk("hold_cipher", 289'(o_cipher_text), 289'(CT2));
    chk("hold_bypass", o_bypass_text, BYP);
    chk("hold_ready", 289'(o_cp_ready), 289'(0));

    // Two three-block messages, i_new every 2 cycles; the counter restarts after the last block.
    for (int m = 0; m < 2; m++) begin
      obs_ct.delete();
      for (int b = 1; b <= 3; b++) begin
        send(PT0, BYP + 289'(b), 1'(b == 3), 1'b1);
        @(negedge clk);
      end
      wait_drain("msg3");
      chk("msg3_ct_first", 289'(obs_ct[0]), 289'(CT2));
      chk("msg3_ct_second", 289'(obs_ct[1]), 289'(CT3));
    end

    // Five back-to-back blocks fit; the sixth finds the FIFO full and is dropped.
    obs_ct.delete();
    for (int b = 0; b < 5; b++) send(rand128(), rand289(), 1'b0, 1'b1);
    send(rand128(), rand289(), 1'b0, 1'b0);
    wait_drain("burst");
    repeat (20) @(negedge clk);
    chk("burst_count", 289'(obs_ct.size()), 289'(5));
    send(rand128(), rand289(), 1'b1, 1'b1);
    wait_drain("burst_close");

    // Reset while a block is in flight: no strobe, outputs cleared, counter back to 2.
    send(rand128(), rand289(), 1'b0, 1'b1);
    wait_drain("pre_reset");
    send(PT0, rand289(), 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    m_ctr = 32'd2;
    core_free = 0;
    repeat (3) @(negedge clk);
    chk("midreset_cipher", 289'(o_cipher_text), 289'(0));
    chk("midreset_bypass", o_bypass_text, 289'(0));
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("postreset_ready", 289'(o_cp_ready), 289'(0));
    chk("postreset_cipher", 289'(o_cipher_text), 289'(0));
    chk("postreset_bypass", o_bypass_text, 289'(0));
    obs_ct.delete();
    send(PT0, BYP, 1'b1, 1'b1);
    wait_drain("after_reset");
    chk("after_reset_ct", 289'(obs_ct[0]), 289'(CT2));

    // Counter wrap: the block after CTR=0xFFFFFFFF must use CTR=0.
    @(negedge clk);
    force dut.ctr = 32'hffff_ffff;
    @(negedge clk);
    release dut.ctr;
    m_ctr = 32'hffff_ffff;
    send(rand128(), rand289(), 1'b0, 1'b1);
    @(negedge clk);
    send(rand128(), rand289(), 1'b0, 1'b1);
    send(rand128(), rand289(), 1'b1, 1'b1);
    wait_drain("wrap");

    repeat (30) @(negedge clk);
    chk("final_queue_empty", 289'(exp_q.size()), 289'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
